// File: rtl/sum_pkg.sv
// Shared definitions for the sum4bit adder and its BCD conversion stage.
package sum_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_t;

    localparam int BCD_DIGIT_W   = 4;
    localparam int ADJ_THRESHOLD = 5;
    localparam int ADJ_ADD       = 3;
    localparam int SUM_W         = 5;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: a digit of 5 or more gets +3 so that
// the following left shift carries correctly into the next decimal digit.
module bcd_digit_adj
    import sum_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] d,
    output logic [BCD_DIGIT_W-1:0] q
);

    assign q = (d >= BCD_DIGIT_W'(ADJ_THRESHOLD)) ? d + BCD_DIGIT_W'(ADJ_ADD) : d;

endmodule

// File: rtl/sum_to_bcd.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one input bit per
// clock) with valid/ready handshakes on both the input and result sides.
module sum_to_bcd
    import sum_pkg::*;
#(
    parameter int IN_W   = SUM_W,
    parameter int DIGITS = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [IN_W-1:0]               in_bin,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
    output logic                          overflow
);

    localparam int BCD_W = BCD_DIGIT_W * DIGITS;
    localparam int CNT_W = $clog2(IN_W + 1);

    state_t             state;
    state_t             state_next;
    logic [IN_W-1:0]    shreg;
    logic [BCD_W-1:0]   digits;
    logic [BCD_W-1:0]   adj;
    logic               ovf;
    logic [CNT_W-1:0]   cnt;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .d (digits[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .q (adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (in_valid) state_next = CONV;
            CONV: if (cnt == CNT_W'(1)) state_next = DONE;
            DONE: if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The bit leaving the top digit is a lost multiple of 10^DIGITS, so it
    // latches into the sticky overflow flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            shreg  <= '0;
            digits <= '0;
            ovf    <= 1'b0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        shreg  <= in_bin;
                        digits <= '0;
                        ovf    <= 1'b0;
                        cnt    <= CNT_W'(IN_W);
                    end
                end
                CONV: begin
                    digits <= {adj[BCD_W-2:0], shreg[IN_W-1]};
                    shreg  <= {shreg[IN_W-2:0], 1'b0};
                    ovf    <= ovf | adj[BCD_W-1];
                    cnt    <= cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign bcd       = digits;
    assign overflow  = ovf;

endmodule
